// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction fetch and {pc, instr} FIFO toward decode; FETCH_ALIGN_TRAP_EN enables misaligned-target trap
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0028,
  parameter int IMEM_WORDS = 250,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  output logic        halt,
  output logic        trap
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [31:0] END_ADDR = 32'(IMEM_WORDS * 4);
  typedef enum logic [1:0] {
    RUN,
    HALT
`ifdef FETCH_ALIGN_TRAP_EN
    , TRAP
`endif
  } state_t;
  state_t state, state_d;
  logic [31:0] pc, pc4, br_tgt, jmp_tgt, raw_tgt, target;
  logic [31:0] q_pc [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic redirect, misalign, full, pop, push, at_end;
  always_comb begin
    pc4 = br_pc + 32'd4;
    br_tgt = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    jmp_tgt = {pc4[31:28], jmp_index, 2'b00};
    raw_tgt = jmp ? jmp_tgt : br_tgt;
`ifdef FETCH_ALIGN_TRAP_EN
    redirect = (br_taken || jmp) && state != TRAP;
    misalign = raw_tgt[1:0] != 2'b00;
    target = raw_tgt;
`else
    redirect = br_taken || jmp;
    misalign = 1'b0;
    target = raw_tgt & ~32'h3;
`endif
    full = count == (AW+1)'(QDEPTH);
    out_valid = count != '0;
    pop = out_valid && out_ready;
    at_end = pc >= END_ADDR;
    push = state == RUN && !at_end && (!full || pop) && !redirect;
    out_pc = out_valid ? q_pc[rd_ptr] : 32'h0;
    out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;
    imem_addr = pc;
    halt = state == HALT;
`ifdef FETCH_ALIGN_TRAP_EN
    trap = state == TRAP;
    state_d = redirect ? (misalign ? TRAP : RUN) : (state == RUN && at_end) ? HALT : state;
`else
    trap = 1'b0;
    state_d = redirect ? RUN : (state == RUN && at_end) ? HALT : state;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      if (redirect) begin
        pc <= target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr] <= pc;
          q_instr[wr_ptr] <= imem_instr;
          wr_ptr <= wr_ptr + 1'b1;
          pc <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch order, stall, redirects, halt and alignment handling
module tb_pc_fetch_unit;
  logic clk = 0, rst = 1;
  logic [31:0] imem_addr, imem_instr, out_instr, out_pc, br_pc;
  logic out_valid, out_ready = 1, br_taken = 0, jmp = 0, halt, trap;
  logic [15:0] br_imm = 0;
  logic [25:0] jmp_index = 0;
  int checks = 0, errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm), .jmp(jmp), .jmp_index(jmp_index),
    .halt(halt), .trap(trap)
  );

  always #5 clk = ~clk;
  assign imem_instr = (imem_addr == 32'h28) ? 32'h2008_0005 : ~imem_addr;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, (pc == 32'h28) ? 32'h2008_0005 : ~pc);
  endtask

  initial begin
    br_pc = 0;
    @(negedge clk);
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_addr", imem_addr, 32'h28);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    rst = 0;
    tick(); head("t1a", 32'h28);
    chk("t1_instr28", out_instr, 32'h2008_0005);
    tick(); head("t1b", 32'h2C);
    tick(); head("t1c", 32'h30);
    tick(); head("t1d", 32'h34);
    rst = 1; tick(); rst = 0; out_ready = 0;
    chk("t2_rst_valid", 32'(out_valid), 0);
    repeat (5) tick();
    head("t2_stall", 32'h28);
    chk("t2_addr", imem_addr, 32'h30);
    out_ready = 1;
    tick(); head("t2b", 32'h2C);
    tick(); head("t2c", 32'h30);
    br_taken = 1; br_pc = 32'h30; br_imm = 16'hFFFE;
    tick(); br_taken = 0;
    chk("t3_flush", 32'(out_valid), 0);
    chk("t3_addr", imem_addr, 32'h2C);
    tick(); head("t3a", 32'h2C);
    tick(); head("t3b", 32'h30);
    jmp = 1; br_taken = 1; br_pc = 32'h40; jmp_index = 26'h20; br_imm = 16'h0010;
    tick(); jmp = 0; br_taken = 0;
    chk("t4_flush", 32'(out_valid), 0);
    tick(); head("t4", 32'h80);
    jmp = 1; br_pc = 0; jmp_index = 26'hF8;
    tick(); jmp = 0;
    chk("t5_flush", 32'(out_valid), 0);
    tick(); head("t5a", 32'h3E0);
    chk("t5a_halt", 32'(halt), 0);
    tick(); head("t5b", 32'h3E4);
    tick();
    chk("t5_halt", 32'(halt), 1);
    chk("t5_drained", 32'(out_valid), 0);
    chk("t5_addr", imem_addr, 32'h3E8);
    tick();
    chk("t5_halt_hold", 32'(halt), 1);
    chk("t5_addr_hold", imem_addr, 32'h3E8);
    jmp = 1; jmp_index = 26'h0A;
    tick(); jmp = 0;
    chk("t5_unhalt", 32'(halt), 0);
    tick(); head("t5c", 32'h28);
    br_taken = 1; br_pc = 32'h26; br_imm = 0;
    tick(); br_taken = 0;
`ifdef FETCH_ALIGN_TRAP_EN
    chk("t6_trap", 32'(trap), 1);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_addr", imem_addr, 32'h2A);
    jmp = 1; jmp_index = 26'h10;
    tick(); jmp = 0;
    tick();
    chk("t6_trap_hold", 32'(trap), 1);
    chk("t6_valid_hold", 32'(out_valid), 0);
    chk("t6_ignore", imem_addr, 32'h2A);
    rst = 1; tick(); rst = 0;
    chk("t6_rst_trap", 32'(trap), 0);
    tick(); head("t6_rst", 32'h28);
`else
    chk("t6_trap", 32'(trap), 0);
    chk("t6_addr", imem_addr, 32'h28);
    tick(); head("t6", 32'h28);
    chk("t6_trap_hold", 32'(trap), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
